alu_seq: RTL and testbench

//   Registered, parametrised successor to the 8-bit add/sub ALU of the CPU datapath. Executes
//   add/sub (with and without carry-in), logic, shift and a multi-cycle unsigned multiply.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_mul_seq.sv | 66 ++++++
 rtl/alu_seq.sv | 142 ++++++++++++++
 tb/tb_alu_seq.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM states and flag layout for the sequential ALU and its controller.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Controller <-> ALU handshake: start/ready issue side, done/result/flags return side.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_f;
  logic             zero_f;
  logic             neg_f;
  logic             ovf_f;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, result, result_hi, carry_f, zero_f, neg_f, ovf_f
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, result, result_hi, carry_f, zero_f, neg_f, ovf_f
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one step per edge; prod_nxt is the product after the current step.
// WIDTH steps after load; caller must not load while stepping.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_nxt
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   add;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  // lo holds the unconsumed multiplier bits and fills with product bits from the top.
  always_comb begin
    add     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    hi_step = add[WIDTH:1];
    lo_step = {add[0], lo_q[WIDTH-1:1]};
  end

  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (load) begin
      mcand_d = a;
      hi_d    = '0;
      lo_d    = b;
      cnt_d   = CNT_W'(WIDTH);
    end else if (step) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last     = (cnt_q == CNT_W'(1));
  assign prod_nxt = {hi_step, lo_step};

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-op results one edge after accept, MUL after WIDTH more edges.
// ready drops only while a MUL is in flight; start is ignored then.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  flags_t             flags_q, flags_d;
  logic               done_q, done_d;

  logic               busy, ready, accept;
  logic               mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] prod_nxt;

  logic [WIDTH-1:0]   b_x;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .load     (mul_load),
    .step     (mul_step),
    .a        (bus.a),
    .b        (bus.b),
    .last     (mul_last),
    .prod_nxt (prod_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && bus.op == OP_MUL) state_d = ST_MUL;
      ST_MUL:  if (mul_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_MUL);
    ready    = ~busy;
    accept   = bus.start && ready;
    mul_load = accept && (bus.op == OP_MUL);
    mul_step = busy;
  end

  // ADC/SBC fold the stored carry in; subtraction is a + ~b + cin.
  always_comb begin
    b_x = (bus.op == OP_SUB || bus.op == OP_SBC) ? ~bus.b : bus.b;
    case (bus.op)
      OP_ADD:  cin = 1'b0;
      OP_SUB:  cin = 1'b1;
      default: cin = flags_q.carry;
    endcase
    sum     = {1'b0, bus.a} + {1'b0, b_x} + (WIDTH+1)'(cin);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_c   = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, bus.a[WIDTH-1:1]};
        alu_c   = bus.a[0];
      end
      default: ;
    endcase
  end

  // Reserved opcodes pulse done but leave result and flags untouched.
  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    if (mul_step && mul_last) begin
      result_d    = prod_nxt[WIDTH-1:0];
      result_hi_d = prod_nxt[2*WIDTH-1:WIDTH];
      flags_d     = '{carry: |prod_nxt[2*WIDTH-1:WIDTH], zero: (prod_nxt == '0),
                      neg: prod_nxt[2*WIDTH-1], ovf: 1'b0};
      done_d      = 1'b1;
    end else if (accept && bus.op != OP_MUL) begin
      done_d = 1'b1;
      if (bus.op <= OP_SHR) begin
        result_d    = alu_res;
        result_hi_d = '0;
        flags_d     = '{carry: alu_c, zero: (alu_res == '0), neg: alu_res[WIDTH-1], ovf: alu_v};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.carry_f   = flags_q.carry;
  assign bus.zero_f    = flags_q.zero;
  assign bus.neg_f     = flags_q.neg;
  assign bus.ovf_f     = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: hand-computed results, flags and handshake timing.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // prod = {result_hi,result}; flg = {carry,zero,neg,ovf}; ctl = {done,busy,ready}
  task automatic expect_out(input string tag, input logic [15:0] prod,
                            input logic [3:0] flg, input logic [2:0] ctl);
    chk({tag, " res"}, {bus.result_hi, bus.result}, prod);
    chk({tag, " flg"}, 16'({bus.carry_f, bus.zero_f, bus.neg_f, bus.ovf_f}), 16'(flg));
    chk({tag, " ctl"}, 16'({bus.done, bus.busy, bus.ready}), 16'(ctl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    drive(op, a, b);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    rst = 1'b0;
    expect_out("reset", 16'h0000, 4'b0000, 3'b001);

    issue(OP_ADD, 8'hFF, 8'h01);
    expect_out("add_ff_01", 16'h0000, 4'b1100, 3'b101);
    tick();
    chk("done_one_cycle", 16'(bus.done), 16'h0000);

    issue(OP_SUB, 8'h05, 8'h07);
    expect_out("sub_05_07", 16'h00FE, 4'b0010, 3'b101);
    issue(OP_SBC, 8'h10, 8'h01);
    expect_out("sbc_borrow", 16'h000E, 4'b1000, 3'b101);

    issue(OP_ADD, 8'h7F, 8'h01);
    expect_out("add_ovf", 16'h0080, 4'b0011, 3'b101);
    issue(OP_SHR, 8'h01, 8'hFF);
    expect_out("shr_01", 16'h0000, 4'b1100, 3'b101);

    // MUL with start pulses during busy that must be ignored
    issue(OP_MUL, 8'hFF, 8'hFF);
    expect_out("mul_t0", 16'h0000, 4'b1100, 3'b010);
    for (int k = 1; k < 8; k++) begin
      if (k >= 2 && k <= 4) drive(OP_ADD, 8'h01, 8'h01);
      else bus.start = 1'b0;
      tick();
      chk("mul_busy_ctl", 16'({bus.done, bus.busy, bus.ready}), 16'(3'b010));
    end
    chk("mul_hold_res", {bus.result_hi, bus.result}, 16'h0000);
    tick();
    expect_out("mul_ff_ff", 16'hFE01, 4'b1010, 3'b101);
    tick();
    chk("mul_done_pulse", 16'(bus.done), 16'h0000);

    // reset mid-MUL
    issue(OP_MUL, 8'h03, 8'h05);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    expect_out("rst_mid_mul", 16'h0000, 4'b0000, 3'b001);
    rst = 1'b0;
    issue(OP_ADD, 8'h02, 8'h03);
    expect_out("add_after_rst", 16'h0005, 4'b0000, 3'b101);

    // back-to-back ADC chain then reserved op
    drive(OP_ADC, 8'hFF, 8'h01);
    tick();
    expect_out("adc_1", 16'h0000, 4'b1100, 3'b101);
    drive(OP_ADC, 8'h00, 8'h00);
    tick();
    expect_out("adc_2", 16'h0001, 4'b0000, 3'b101);
    drive(4'd12, 8'h55, 8'hAA);
    tick();
    bus.start = 1'b0;
    expect_out("reserved_a", 16'h0001, 4'b0000, 3'b101);

    // MUL with zero low half but non-zero product, then reserved keeps result_hi
    issue(OP_MUL, 8'h10, 8'h20);
    for (int k = 1; k < 8; k++) tick();
    chk("mul2_not_done", 16'(bus.done), 16'h0000);
    tick();
    expect_out("mul_10_20", 16'h0200, 4'b1000, 3'b101);
    issue(4'd12, 8'h00, 8'h00);
    expect_out("reserved_b", 16'h0200, 4'b1000, 3'b101);

    issue(OP_XOR, 8'hF0, 8'hFF);
    expect_out("xor", 16'h000F, 4'b0000, 3'b101);
    issue(OP_SHL, 8'h81, 8'h00);
    expect_out("shl", 16'h0002, 4'b1000, 3'b101);
    issue(OP_AND, 8'h0F, 8'hF0);
    expect_out("and", 16'h0000, 4'b0100, 3'b101);
    issue(OP_OR, 8'h80, 8'h01);
    expect_out("or", 16'h0081, 4'b0010, 3'b101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
